// File: rtl/musk_reg_writeback_pkg.sv
// Shared register-map types and helpers for the write-back path: register ids,
// values, scoreboard masks and the FIFO entry format.
package musk_reg_writeback_pkg;

    localparam int REG_FILE_SIZE = 8;
    localparam int REG_IDX_W     = $clog2(REG_FILE_SIZE);

    typedef logic [3:0]                 reg_id_t;
    typedef logic [31:0]                reg_val_t;
    typedef logic [0:REG_FILE_SIZE-1]   sb_mask_t;

    localparam reg_id_t RAX  = 4'd0;
    localparam reg_id_t RCX  = 4'd1;
    localparam reg_id_t RDX  = 4'd2;
    localparam reg_id_t RBX  = 4'd3;
    localparam reg_id_t RSP  = 4'd4;
    localparam reg_id_t RBP  = 4'd5;
    localparam reg_id_t RSI  = 4'd6;
    localparam reg_id_t RDI  = 4'd7;
    // Ids from here up name operands that never live in the register file.
    localparam reg_id_t RIMM = 4'd8;

    typedef struct packed {
        reg_id_t  dst_id;
        reg_val_t val;
    } wb_entry_t;

    function automatic logic reg_in_file(input reg_id_t id);
        return id < reg_id_t'(REG_FILE_SIZE);
    endfunction

    function automatic logic [REG_IDX_W-1:0] reg_num(input reg_id_t id);
        return id[REG_IDX_W-1:0];
    endfunction

    function automatic sb_mask_t make_dst_sb_mask(input reg_id_t id);
        sb_mask_t m;
        m = '0;
        if (reg_in_file(id)) begin
            m[reg_num(id)] = 1'b1;
        end
        return m;
    endfunction

    // Mirror of make_dst_sb_mask for the retire side; invalid ids clear nothing.
    function automatic sb_mask_t make_clear_mask(input reg_id_t id);
        sb_mask_t m;
        m = '0;
        if (reg_in_file(id)) begin
            m[reg_num(id)] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/musk_reg_writeback_if.sv
// Result handshake between an execution unit (master) and the write-back block (slave).
interface musk_reg_writeback_if;
    import musk_reg_writeback_pkg::*;

    logic     res_valid;
    logic     res_ready;
    reg_id_t  res_dst_id;
    reg_val_t res_val;

    modport master (
        output res_valid,
        output res_dst_id,
        output res_val,
        input  res_ready
    );

    modport slave (
        input  res_valid,
        input  res_dst_id,
        input  res_val,
        output res_ready
    );

endinterface

// File: rtl/musk_wb_fifo.sv
// Result FIFO for write-back: single push/pop per cycle, flush empties it, and
// full/empty/count are all registered so downstream ready paths stay short.
module musk_wb_fifo
    import musk_reg_writeback_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH) + 1,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  wb_entry_t        din,
    output wb_entry_t        dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    wb_entry_t        r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd;
    logic [PTR_W-1:0] r_wr;
    logic [CNT_W-1:0] r_count;
    logic             r_full;
    logic             r_empty;

    logic             w_push;
    logic             w_pop;
    logic [CNT_W-1:0] w_count_nxt;

    // Flush wins over both ports so a cancelled head and a same-cycle push vanish together.
    assign w_push = push && !r_full  && !flush;
    assign w_pop  = pop  && !r_empty && !flush;

    always_comb begin
        w_count_nxt = r_count;
        if (flush) begin
            w_count_nxt = '0;
        end else if (w_push && !w_pop) begin
            w_count_nxt = r_count + CNT_W'(1);
        end else if (w_pop && !w_push) begin
            w_count_nxt = r_count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CNT_W'(DEPTH));
            r_empty <= (w_count_nxt == '0);
            if (flush) begin
                r_rd <= r_wr;
            end else begin
                if (w_pop) begin
                    r_rd <= r_rd + PTR_W'(1);
                end
                if (w_push) begin
                    r_wr <= r_wr + PTR_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr] <= din;
        end
    end

    assign dout  = r_mem[r_rd];
    assign full  = r_full;
    assign empty = r_empty;
    assign count = r_count;

endmodule

// File: rtl/musk_reg_writeback.sv
// Write-back stage: buffers completed results, retires one per cycle into the
// architectural register file and maintains the scoreboard busy bits.
module musk_reg_writeback
    import musk_reg_writeback_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  sb_set,
    input  sb_mask_t              sb_set_mask,
    input  logic                  flush,
    musk_reg_writeback_if.slave   res,
    output reg_val_t              reg_file [0:REG_FILE_SIZE-1],
    output sb_mask_t              sb,
    output logic                  wb_err
);

    reg_val_t         r_reg_file [0:REG_FILE_SIZE-1];
    sb_mask_t         r_sb;
    logic             r_wb_err;
    logic             r_live;

    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic [CNT_W-1:0] w_count;
    wb_entry_t        w_in;
    wb_entry_t        w_head;
    logic             w_head_ok;
    sb_mask_t         w_set_mask;
    sb_mask_t         w_clear_mask;
    sb_mask_t         w_sb_nxt;
    logic             w_err_evt;

    // Ready is held low until the first edge out of reset, then tracks the registered full flag.
    assign res.res_ready = r_live && !w_full;

    assign w_push        = res.res_valid && res.res_ready;
    assign w_pop         = !w_empty && !flush;
    assign w_in.dst_id   = res.res_dst_id;
    assign w_in.val      = res.res_val;

    musk_wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (w_push),
        .pop     (!w_empty),
        .flush   (flush),
        .din     (w_in),
        .dout    (w_head),
        .full    (w_full),
        .empty   (w_empty),
        .count   (w_count)
    );

    assign w_head_ok    = reg_in_file(w_head.dst_id);
    assign w_set_mask   = sb_set ? sb_set_mask : '0;
    assign w_clear_mask = w_pop ? make_clear_mask(w_head.dst_id) : '0;

    // A bit both set and cleared this edge stays busy: the new owner's write is still pending.
    assign w_sb_nxt = flush ? '0 : ((r_sb & ~w_clear_mask) | w_set_mask);

    assign w_err_evt = (w_pop && !w_head_ok)
                     || (|(w_set_mask & w_clear_mask))
                     || (|(w_set_mask & r_sb));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_live   <= 1'b0;
            r_sb     <= '0;
            r_wb_err <= 1'b0;
        end else begin
            r_live <= 1'b1;
            r_sb   <= w_sb_nxt;
            if (w_err_evt) begin
                r_wb_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < REG_FILE_SIZE; i++) begin
                r_reg_file[i] <= '0;
            end
        end else if (w_pop && w_head_ok) begin
            r_reg_file[reg_num(w_head.dst_id)] <= w_head.val;
        end
    end

    assign reg_file = r_reg_file;
    assign sb       = r_sb;
    assign wb_err   = r_wb_err;

endmodule

// File: tb/tb_musk_reg_writeback.sv
// Directed and random bench for musk_reg_writeback with a queue-based result model.
module tb_musk_reg_writeback;
    import musk_reg_writeback_pkg::*;

    localparam int DEPTH = 4;

    logic     clk = 1'b0;
    logic     reset_n = 1'b0;
    logic     sb_set = 1'b0;
    sb_mask_t sb_set_mask = '0;
    logic     flush = 1'b0;
    reg_val_t reg_file [0:REG_FILE_SIZE-1];
    sb_mask_t sb;
    logic     wb_err;

    musk_reg_writeback_if res_if ();

    musk_reg_writeback #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .sb_set      (sb_set),
        .sb_set_mask (sb_set_mask),
        .flush       (flush),
        .res         (res_if),
        .reg_file    (reg_file),
        .sb          (sb),
        .wb_err      (wb_err)
    );

    always #5 clk = ~clk;

    int        checks = 0;
    int        errors = 0;
    wb_entry_t m_q [$];
    reg_val_t  m_rf [REG_FILE_SIZE];
    sb_mask_t  m_sb;
    logic      m_err;
    logic      m_live;
    int        n_push = 0;

    function automatic sb_mask_t bit_of(input reg_id_t id);
        sb_mask_t m;
        m = '0;
        if (id < 4'd8) m[id[2:0]] = 1'b1;
        return m;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, " res_ready"}, 64'(res_if.res_ready),
              64'(m_live && (m_q.size() != DEPTH)));
        check({tag, " sb"}, 64'(sb), 64'(m_sb));
        check({tag, " wb_err"}, 64'(wb_err), 64'(m_err));
        check({tag, " count"}, 64'(dut.w_count), 64'(m_q.size()));
        for (int i = 0; i < REG_FILE_SIZE; i++) begin
            check($sformatf("%s rf[%0d]", tag, i), 64'(reg_file[i]), 64'(m_rf[i]));
        end
    endtask

    // Drive one cycle of inputs, advance the model across the edge, then compare.
    task automatic step(input string tag, input logic v, input reg_id_t id, input reg_val_t val,
                        input logic ss, input sb_mask_t mask, input logic fl);
        logic      acc;
        logic      pop;
        sb_mask_t  setm;
        sb_mask_t  clr;
        wb_entry_t e;
        res_if.res_valid  = v;
        res_if.res_dst_id = id;
        res_if.res_val    = val;
        sb_set            = ss;
        sb_set_mask       = mask;
        flush             = fl;
        @(posedge clk);
        acc  = v && m_live && (m_q.size() != DEPTH) && !fl;
        pop  = (m_q.size() != 0) && !fl;
        setm = ss ? mask : '0;
        clr  = '0;
        if (pop) begin
            e = m_q.pop_front();
            if (e.dst_id < 4'd8) begin
                m_rf[e.dst_id[2:0]] = e.val;
                clr = bit_of(e.dst_id);
            end else begin
                m_err = 1'b1;
            end
        end
        if ((|(setm & clr)) || (|(setm & m_sb))) m_err = 1'b1;
        m_sb = fl ? '0 : ((m_sb & ~clr) | setm);
        if (fl) begin
            m_q.delete();
        end else if (acc) begin
            e.dst_id = id;
            e.val    = val;
            m_q.push_back(e);
            n_push++;
        end
        m_live = 1'b1;
        #1;
        check_all(tag);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, RAX, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic do_reset(input string tag);
        reset_n           = 1'b0;
        res_if.res_valid  = 1'b0;
        res_if.res_dst_id = RAX;
        res_if.res_val    = '0;
        sb_set            = 1'b0;
        sb_set_mask       = '0;
        flush             = 1'b0;
        m_q.delete();
        for (int i = 0; i < REG_FILE_SIZE; i++) m_rf[i] = '0;
        m_sb   = '0;
        m_err  = 1'b0;
        m_live = 1'b0;
        #2;
        check({tag, " in-reset res_ready"}, 64'(res_if.res_ready), 64'd0);
        check({tag, " in-reset count"}, 64'(dut.w_count), 64'd0);
        check({tag, " in-reset sb"}, 64'(sb), 64'd0);
        for (int i = 0; i < REG_FILE_SIZE; i++) begin
            check($sformatf("%s in-reset rf[%0d]", tag, i), 64'(reg_file[i]), 64'd0);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        m_live = 1'b1;
        #1;
        check({tag, " ready after release"}, 64'(res_if.res_ready), 64'd1);
        check_all({tag, " post"});
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: single result to rax
        do_reset("t1");
        step("t1 set", 1'b0, RAX, '0, 1'b1, bit_of(RAX), 1'b0);
        step("t1 push", 1'b1, RAX, 32'h1234, 1'b0, '0, 1'b0);
        check("t1 latency rf", 64'(reg_file[0]), 64'd0);
        check("t1 latency sb", 64'(sb[0]), 64'd1);
        idle("t1 retire");
        check("t1 rf rax", 64'(reg_file[0]), 64'h1234);
        check("t1 sb rax", 64'(sb[0]), 64'd0);
        check("t1 wb_err", 64'(wb_err), 64'd0);

        // 2: back-to-back stream, then reset with an entry queued
        for (int i = 0; i < 2 * DEPTH; i++) begin
            step("t2 stream", 1'b1, reg_id_t'(i % 8), reg_val_t'(32'h100 + i), 1'b0, '0, 1'b0);
            check("t2 ready held", 64'(res_if.res_ready), 64'd1);
        end
        check("t2 queued", 64'(dut.w_count), 64'd1);
        #2;
        do_reset("t2 reset");

        // 3: two results to rcx, last wins
        step("t3 set", 1'b0, RAX, '0, 1'b1, bit_of(RCX), 1'b0);
        step("t3 push1", 1'b1, RCX, 32'd1, 1'b0, '0, 1'b0);
        step("t3 push2", 1'b1, RCX, 32'd2, 1'b0, '0, 1'b0);
        check("t3 rf rcx T+1", 64'(reg_file[1]), 64'd1);
        idle("t3 retire2");
        check("t3 rf rcx T+2", 64'(reg_file[1]), 64'd2);
        check("t3 sb rcx", 64'(sb[1]), 64'd0);

        // 4: flush cancels the retiring head and a same-cycle push
        step("t4 pre", 1'b1, RBX, 32'h55, 1'b0, '0, 1'b0);
        idle("t4 pre retire");
        step("t4 set", 1'b0, RAX, '0, 1'b1, bit_of(RSI), 1'b0);
        step("t4 push", 1'b1, RBX, 32'hAA, 1'b0, '0, 1'b0);
        step("t4 flush", 1'b1, RBX, 32'hBB, 1'b0, '0, 1'b1);
        check("t4 rf rbx", 64'(reg_file[3]), 64'h55);
        check("t4 sb", 64'(sb), 64'd0);
        check("t4 count", 64'(dut.w_count), 64'd0);
        idle("t4 after");
        check("t4 rf rbx kept", 64'(reg_file[3]), 64'h55);
        check("t4 ready", 64'(res_if.res_ready), 64'd1);
        step("t4 push rdi", 1'b1, RDI, 32'd7, 1'b0, '0, 1'b0);
        idle("t4 retire rdi");
        check("t4 rf rdi", 64'(reg_file[7]), 64'd7);

        // 5: set/clear collision and an out-of-file destination
        check("t5 err clear", 64'(wb_err), 64'd0);
        step("t5 set", 1'b0, RAX, '0, 1'b1, bit_of(RDX), 1'b0);
        step("t5 push", 1'b1, RDX, 32'h99, 1'b0, '0, 1'b0);
        step("t5 collide", 1'b0, RAX, '0, 1'b1, bit_of(RDX), 1'b0);
        check("t5 sb rdx", 64'(sb[2]), 64'd1);
        check("t5 wb_err", 64'(wb_err), 64'd1);
        do_reset("t5 reset");
        step("t5 push rimm", 1'b1, RIMM, 32'hDEAD, 1'b0, '0, 1'b0);
        check("t5 err before retire", 64'(wb_err), 64'd0);
        idle("t5 retire rimm");
        check("t5 rimm err", 64'(wb_err), 64'd1);
        check("t5 rimm rf0", 64'(reg_file[0]), 64'd0);

        // 6: random stream with flushes
        do_reset("t6");
        n_push = 0;
        for (int i = 0; i < 300; i++) begin
            logic     v;
            logic     fl;
            logic     ss;
            reg_id_t  id;
            v  = ($urandom % 4) != 0;
            fl = ($urandom % 12) == 0;
            ss = !fl && (($urandom % 8) == 0);
            id = reg_id_t'($urandom_range(0, 9));
            step("t6 rand", v, id, reg_val_t'($urandom), ss,
                 bit_of(reg_id_t'($urandom_range(0, 7))), fl);
        end
        check("t6 wrap pushes", 64'(n_push > 2 * DEPTH), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
